// File: rtl/serial_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// serial_arbiter_pkg
// Shared definitions for the serial arbiter slice:
//   - default parameter values (requester count, word width, busy timeout)
//   - the arbiter FSM state type
//   - width helpers for the priority pointer and the timeout counter
// -----------------------------------------------------------------------------
package serial_arbiter_pkg;

   localparam int DEF_N_REQ = 4;   // requesters sharing the sender
   localparam int DEF_DW    = 5;   // sender word width
   localparam int DEF_TMO   = 15;  // cycles allowed for mesgul to rise

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   // Index width for n requesters; never zero so a single-requester build
   // still has a legal vector.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // ceil(log2(tmo+1)): enough bits to hold every count 0..tmo.
   function automatic int cnt_width(input int tmo);
      return (tmo > 0) ? $clog2(tmo + 1) : 1;
   endfunction

endpackage

// File: rtl/serial_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector.
//   req    [N-1:0]  : pending requests
//   ptr    [PW-1:0] : index where the search starts (last winner + 1)
//   winner [N-1:0]  : one-hot first set request at or after ptr (wrapping)
//   valid           : at least one request is pending
// -----------------------------------------------------------------------------
module rr_picker
   import serial_arbiter_pkg::*;
#(
   parameter int N  = DEF_N_REQ,
   parameter int PW = ptr_width(DEF_N_REQ)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          valid
);

   logic [PW-1:0] idx;

   // NOTE: every output of this block gets a default before the search loop,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(ptr) + i) % N);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/serial_arbiter.sv
// -----------------------------------------------------------------------------
// serial_arbiter
// Shares one serial sender between N_REQ requesters. A winner is chosen
// round-robin while the sender is idle, its word is latched onto D, and the
// sender is started with a one-cycle baslat pulse. The transfer ends with a
// done pulse to the owner when mesgul falls, or with an err pulse if mesgul
// never rises within TMO cycles of the start.
//
// Ports
//   clk     : clock, all state changes on the rising edge
//   reset   : asynchronous active-low reset
//   req     : per-requester request level, held until gnt
//   data    : packed words, requester i at [i*DW +: DW]
//   gnt     : one-hot pulse, word of that requester has been latched
//   done    : one-hot pulse, that requester's transfer has finished
//   err     : pulse, sender never went busy after baslat
//   baslat  : one-cycle start pulse to the sender
//   D       : word to the sender, held from grant until the next grant
//   mesgul  : sender busy flag
// -----------------------------------------------------------------------------
module serial_arbiter
   import serial_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int DW    = DEF_DW,
   parameter int TMO   = DEF_TMO
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] data,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic                err,
   output logic                baslat,
   output logic [DW-1:0]       D,
   input  logic                mesgul
);

   localparam int            PW       = ptr_width(N_REQ);
   localparam int            CW       = cnt_width(TMO);
   localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

   state_t           state;
   logic [PW-1:0]    ptr;       // search start for the next arbitration
   logic [PW-1:0]    owner;     // requester whose word is on D
   logic [CW-1:0]    cnt;       // cycles spent waiting for mesgul
   logic [N_REQ-1:0] pick_oh;
   logic             pick_valid;
   logic [PW-1:0]    pick_idx;
   logic [PW-1:0]    ptr_next;
   logic [DW-1:0]    words [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_words
      assign words[g] = data[g*DW +: DW];
   end

   rr_picker #(
      .N  (N_REQ),
      .PW (PW)
   ) u_picker (
      .req    (req),
      .ptr    (ptr),
      .winner (pick_oh),
      .valid  (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) pick_idx = PW'(i);
      end
   end

   // The winner becomes the lowest priority for the next round.
   assign ptr_next = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;

   // NOTE: all state and outputs here are flops, so every assignment is
   // non-blocking; blocking assignments would make the result depend on
   // statement order and simulate differently from the synthesized logic.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         ptr    <= '0;
         owner  <= '0;
         cnt    <= '0;
         gnt    <= '0;
         done   <= '0;
         err    <= 1'b0;
         baslat <= 1'b0;
         D      <= '0;
      end else begin
         // Pulse outputs are low unless the current state raises them.
         gnt    <= '0;
         done   <= '0;
         err    <= 1'b0;
         baslat <= 1'b0;

         case (state)
            IDLE: begin
               // An externally busy sender blocks arbitration entirely.
               if (pick_valid && !mesgul) begin
                  gnt   <= pick_oh;
                  D     <= words[pick_idx];
                  owner <= pick_idx;
                  ptr   <= ptr_next;
                  state <= START;
               end
            end

            START: begin
               baslat <= 1'b1;
               cnt    <= '0;
               state  <= WAIT_BUSY;
            end

            WAIT_BUSY: begin
               // mesgul seen on the last allowed cycle still wins over err.
               if (mesgul) begin
                  state <= WAIT_DONE;
               end else if (cnt == CNT_LAST) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            WAIT_DONE: begin
               if (!mesgul) begin
                  done  <= N_REQ'(1) << owner;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/serial_arbiter.md
SERIAL_ARBITER -- requirements
Module: serial_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing one serial sender.
REQ-002 Parameter DW, 5, data word width; equals sender D width.
REQ-003 Parameter TMO, 15, max cycles to wait for mesgul to rise after baslat.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester transfer request, level, held until gnt.
REQ-007 data  input  N_REQ*DW  packed words; requester i at bits [i*DW +: DW].
REQ-008 gnt  output  N_REQ  one-hot, one-cycle pulse: word of requester i latched.
REQ-009 done  output  N_REQ  one-hot, one-cycle pulse: requester i transfer finished.
REQ-010 err  output  1  one-cycle pulse: sender never asserted mesgul within TMO cycles.
REQ-011 baslat  output  1  start pulse to sender.
REQ-012 D  output  DW  word to sender; stable from baslat until mesgul falls.
REQ-013 mesgul  input  1  sender busy flag.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: if any req bit set and mesgul=0, SHALL pick winner, latch data word into D, pulse gnt[winner], go START next cycle.
REQ-016 IDLE with mesgul=1 (sender busy externally) SHALL grant nothing and stay IDLE.
REQ-017 Winner SHALL be round-robin: search starts at (last winner+1) mod N_REQ, first set req bit wins.
REQ-018 START: baslat=1 for exactly one cycle, then WAIT_BUSY; baslat=0 in all other states.
REQ-019 WAIT_BUSY: on mesgul=1 go WAIT_DONE; after TMO cycles without mesgul, pulse err, go IDLE, no done pulse, pointer still advances.
REQ-020 WAIT_DONE: on mesgul=0 pulse done[owner], go IDLE; no timeout in this state.
REQ-021 Latency req->baslat SHALL be 2 cycles when granted directly from IDLE.
REQ-022 Minimum gap between successive baslat pulses: done cycle + IDLE grant + START.
REQ-023 req changes after gnt SHALL NOT affect D or the current transfer.
REQ-024 req deasserted before grant SHALL be ignored; no gnt, no done.
REQ-025 Owner holding req after done SHALL get lowest priority next round.
REQ-026 Single requester alone SHALL be re-granted back-to-back.
REQ-027 gnt, done, err SHALL be mutually exclusive in any cycle and at most one bit high each.

Reset
REQ-028 On reset low: state IDLE, baslat=0, gnt=0, done=0, err=0, D=0, timeout counter 0, priority pointer such that requester 0 wins first.
REQ-029 Reset mid-transfer SHALL drop baslat immediately and issue no done for the aborted word.
REQ-030 Outputs SHALL be registered; no combinational path from req/mesgul to baslat.

Structure
REQ-031 Shared package SHALL hold the state enum and defaults N_REQ, DW, TMO.
REQ-032 Round-robin selection SHALL be one combinational sub-module rr_picker (req, pointer -> one-hot winner, valid).
REQ-033 Timeout counter width SHALL be ceil(log2(TMO+1)).

Verification
REQ-034 Single: req=0001, data0=01010, sender busy 6 cycles -> gnt=0001 t+1, baslat t+2, D=01010, done=0001 after mesgul falls.
REQ-035 Contention: req=1111 held, data i=i+1 -> grant order 0,1,2,3,0, D=00001,00010,00011,00100.
REQ-036 Pointer: after requester 2 wins, req=0101 -> requester 0 wins, not 2.
REQ-037 Timeout: mesgul tied 0 -> err pulse 15 cycles after WAIT_BUSY entry, no done, back to IDLE.
REQ-038 External busy: mesgul=1 in IDLE with req=0010 -> no gnt until mesgul=0.
REQ-039 Reset in WAIT_DONE -> baslat/gnt/done 0 immediately, next grant goes to requester 0.
